// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state encoding.
// Used by the buffered transmitter and its 16x-oversampling receiver counterpart.
package uart_pkg;

  // Frame geometry common to both directions
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);

  // Receiver samples each bit at the middle oversample tick
  localparam int unsigned RX_SAMPLE_POINT = OVERSAMPLE / 2;

  // Tick divider width covers the full CLK_DIV range
  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity bit: set when the byte holds an odd number of ones
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready byte interface feeding the buffered UART transmitter.
interface uart_tx_buffered_if;

  logic [uart_pkg::DATA_BITS-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, 16x-oversampled
// frame encoder on txd. Default frame is 8N1; defining UART_TX_PARITY_EN
// inserts an even-parity bit before the stop bit (8E1).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_DIV    = 326,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                sysclk,
  input  logic                reset,
  uart_tx_buffered_if.slave   tx_in,
  output logic                txd,
  output logic                tx_busy,
  output logic [CNT_W-1:0]    fifo_count
);

  tx_state_e              state;
  logic [DIV_W-1:0]       div_q;
  logic [OS_W-1:0]        os_q;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_BITS-1:0]   shift_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif
  logic                   ready_q;

  logic [DATA_BITS-1:0]   head;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   tick;
  logic                   bit_end;
  logic                   next_idle;

  // Byte buffer between the handshake and the frame encoder
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (sysclk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (tx_in.tx_data),
    .rdata (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign fifo_count     = cnt;
  assign tx_in.tx_ready = ready_q;

  // Handshake, bit timing and occupancy forecast
  always_comb begin
    push      = tx_in.tx_valid && ready_q && !full;
    tick      = (div_q == DIV_W'(CLK_DIV - 1));
    bit_end   = tick && (os_q == OS_W'(OVERSAMPLE - 1));
    pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    next_idle = ((state == IDLE) && empty) || ((state == STOP) && bit_end && empty);
    cnt_next  = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  // Frame encoder FSM with registered txd, busy and ready
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      div_q    <= '0;
      os_q     <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
      tx_busy  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (cnt_next != CNT_W'(FIFO_DEPTH));
      tx_busy <= !next_idle || (cnt_next != '0);

      // Bit timing runs only while a frame is on the line
      if (state != IDLE) begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) os_q <= os_q + 1'b1;
      end

      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(head);
`endif
            state    <= START;
            txd      <= 1'b0;
            div_q    <= '0;
            os_q     <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= shift_q[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_q;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              txd     <= shift_q[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif

        STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            if (pop) begin
              // Next byte starts immediately: no idle gap between frames
              shift_q  <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= even_parity(head);
`endif
              state    <= START;
              txd      <= 1'b0;
              div_q    <= '0;
              os_q     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
UART transmit path with an input FIFO, fed by a valid/ready byte interface, producing a standard 8N1 frame on txd at 16x-oversampled baud timing.
It is the counterpart of the existing 16x-oversampling receiver: the receive path decodes frames, this block buffers bytes and encodes them.
It replaces the level-toggled tx_en/tx_status handshake of the current sender with a single-clock sysclk design and a lossless back-pressure interface.

Parameters:
CLK_DIV, 326, sysclk cycles per oversample tick (50 MHz / (16*9600)); legal range 2..65535
FIFO_DEPTH, 4, byte entries; power of two, 2..16

Ports:
sysclk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data is valid this cycle
tx_ready  output  1  FIFO can accept; transfer occurs on an edge where tx_valid && tx_ready
txd  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored

Behaviour:
- Reset (reset==0 at an edge): txd=1, tx_busy=0, tx_ready=0 while reset is held, then 1 on the first edge after release. fifo_count=0, FSM=IDLE, tick divider=0, FIFO pointers cleared.
- Reset mid-frame: the frame is aborted. txd returns high at that edge and the FIFO contents are discarded.
- tx_ready = (fifo_count != FIFO_DEPTH), derived from registered state only.
- A push and a pop in the same cycle leave fifo_count unchanged. A push while full is ignored.
- Tick divider: counts 0..CLK_DIV-1 only while FSM != IDLE and emits a one-cycle tick at CLK_DIV-1. It is forced to 0 on entry to START, so every bit lasts exactly 16*CLK_DIV sysclk cycles.
- Oversample counter: 4 bits, 0..15, advances on each tick. Wrap from 15 to 0 ends the current bit.
- FSM states and transitions:
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register, go to START, txd=0 on the same edge.
  - START: txd=0 for 16 ticks, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first; shift right each bit end. After bit index 7 ends, go to PARITY (when enabled) or STOP.
  - STOP: txd=1 for 16 ticks. At the end: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: byte accepted at edge k into an empty FIFO with FSM IDLE -> txd falls at edge k+1 (FIFO write at k, visible to FSM, popped at k+1).
- Frame length: 10*16*CLK_DIV cycles (11*16*CLK_DIV with parity). Back-to-back frames are contiguous.
- tx_busy = (FSM != IDLE) || (fifo_count != 0), registered.
- tx_data is sampled only on an accepting edge. Bytes are transmitted in strict FIFO order.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state after DATA. txd = even parity (XOR of the 8 data bits, captured at pop) for 16 ticks, then STOP. Frame is 8E1.
- Undefined: no PARITY state, no parity register. Frame is 8N1.

Decomposition:
- Package uart_pkg: OVERSAMPLE=16, DATA_BITS=8, and the tx FSM state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit).
- The existing receiver's counterpart constants live in the same package.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/count/full/empty, parameterised by FIFO_DEPTH, first-word-fall-through read.

Test Plan:
- CLK_DIV=4; push 0xA5 at edge 10 -> txd low edges 11..74. Then bits 1,0,1,0,0,1,0,1 at 64 cycles each, then stop high 64 cycles. tx_busy falls at edge 651.
- Push 0x00,0xFF,0x55 back-to-back with tx_valid held -> three contiguous frames, 1920 cycles total, no idle between stop and next start, order preserved.
- FIFO_DEPTH=4: push 6 bytes with tx_valid held high -> tx_ready low once fifo_count=4. Exactly 6 frames eventually sent, none dropped or duplicated. Push while full with no pop -> fifo_count stays 4.
- Push while full in the same cycle as the FSM pop -> pop is taken, push is refused (tx_ready=0), fifo_count goes 4->3.
- Assert reset at the DATA bit-3 midpoint with 2 bytes queued -> next edge txd=1, fifo_count=0, tx_busy=0. After release, push 0x3C -> a clean frame.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1 for 64 cycles before the stop bit. Send 0x03 -> parity 0. Frame length is 704 cycles.
